// File: rtl/pkt_buffer_wr_agent_if.sv
// Signal bundle for the packet-buffer write agent: the AXI-Stream beat and control inputs,
// plus the RAM write port, the PIFO push, flow control and the drop counter outputs.
interface pkt_buffer_wr_agent_if #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int ADDR_WIDTH           = 12
) ();
  logic [C_S_AXIS_DATA_WIDTH-1:0]  s_axis_tdata;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser;
  logic                            s_axis_tvalid;
  logic                            s_axis_tready;
  logic                            s_axis_tlast;
  logic                            s_ctl_pifo_in_en;
  logic                            s_ctl_buffer_wr_en;
  logic                            s_free_valid;
  logic                            m_mem_wr_en;
  logic [ADDR_WIDTH-1:0]           m_mem_wr_addr;
  logic [C_S_AXIS_DATA_WIDTH:0]    m_mem_wr_data;
  logic                            m_pifo_in_valid;
  logic [31:0]                     m_pifo_in_data;
  logic                            m_buffer_almost_full;
  logic [31:0]                     m_drop_count;

  modport slave (
    input  s_axis_tdata, s_axis_tuser, s_axis_tvalid, s_axis_tready, s_axis_tlast,
    input  s_ctl_pifo_in_en, s_ctl_buffer_wr_en, s_free_valid,
    output m_mem_wr_en, m_mem_wr_addr, m_mem_wr_data, m_pifo_in_valid, m_pifo_in_data,
    output m_buffer_almost_full, m_drop_count
  );

  modport master (
    output s_axis_tdata, s_axis_tuser, s_axis_tvalid, s_axis_tready, s_axis_tlast,
    output s_ctl_pifo_in_en, s_ctl_buffer_wr_en, s_free_valid,
    input  m_mem_wr_en, m_mem_wr_addr, m_mem_wr_data, m_pifo_in_valid, m_pifo_in_data,
    input  m_buffer_almost_full, m_drop_count
  );
endinterface

// File: rtl/pkt_buffer_wr_agent.sv
// Packet buffer write agent: writes accepted packet beats into a circular buffer RAM,
// pushes one PIFO descriptor per complete packet, and discards packets that overflow.
module pkt_buffer_wr_agent #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int ADDR_WIDTH           = 12,
  parameter int AF_THRESH            = 3968,
  parameter int RANK_POS             = 48
) (
  input logic                  axis_aclk,
  input logic                  axis_reset,
  pkt_buffer_wr_agent_if.slave bus
);

  localparam int OCC_W = ADDR_WIDTH + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [OCC_W-1:0] AF_OCC   = OCC_W'(AF_THRESH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [ADDR_WIDTH-1:0]        wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]        sop_addr_q, sop_addr_d;
  logic [18:0]                  rank_q, rank_d;
  logic [OCC_W-1:0]             pkt_words_q, pkt_words_d;
  logic [OCC_W-1:0]             occ_q, occ_d;
  logic [31:0]                  drop_q, drop_d;
  logic                         mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_WIDTH-1:0]        mem_wr_addr_q, mem_wr_addr_d;
  logic [C_S_AXIS_DATA_WIDTH:0] mem_wr_data_q, mem_wr_data_d;
  logic                         pifo_valid_q, pifo_valid_d;
  logic [31:0]                  pifo_data_q, pifo_data_d;
  logic                         af_q, af_d;

  logic                         accept;
  logic                         full;
  logic                         free_ok;
  logic                         do_write;
  logic                         emit;
  logic [18:0]                  emit_rank;
  logic [ADDR_WIDTH-1:0]        emit_sop;
  logic [OCC_W-1:0]             rollback;
  logic [18:0]                  beat_rank;
  logic [31:0]                  drop_inc;
  logic                         unused_tuser;

  assign accept    = bus.s_axis_tvalid & bus.s_axis_tready & bus.s_ctl_buffer_wr_en;
  assign full      = (occ_q == OCC_FULL);
  // A release with nothing buffered is a read-side glitch; never let occupancy underflow.
  assign free_ok   = bus.s_free_valid & (occ_q != '0);
  assign beat_rank = bus.s_axis_tuser[RANK_POS +: 19];
  assign drop_inc  = (drop_q == 32'hFFFF_FFFF) ? drop_q : drop_q + 32'd1;
  assign unused_tuser = ^bus.s_axis_tuser;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    sop_addr_d  = sop_addr_q;
    rank_d      = rank_q;
    pkt_words_d = pkt_words_q;
    drop_d      = drop_q;
    do_write    = 1'b0;
    emit        = 1'b0;
    emit_rank   = rank_q;
    emit_sop    = sop_addr_q;
    rollback    = '0;

    case (state_q)
      S_IDLE: begin
        // Beats without the PIFO enable are tails of abandoned packets and are dropped silently.
        if (accept && bus.s_ctl_pifo_in_en) begin
          if (full) begin
            drop_d      = drop_inc;
            pkt_words_d = '0;
            if (!bus.s_axis_tlast) state_d = S_DISCARD;
          end else begin
            do_write    = 1'b1;
            sop_addr_d  = wr_ptr_q;
            rank_d      = beat_rank;
            pkt_words_d = OCC_W'(1);
            wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(1);
            if (bus.s_axis_tlast) begin
              emit      = 1'b1;
              emit_rank = beat_rank;
              emit_sop  = wr_ptr_q;
            end else begin
              state_d = S_WRITE;
            end
          end
        end
      end
      S_WRITE: begin
        if (accept) begin
          if (full) begin
            wr_ptr_d    = sop_addr_q;
            rollback    = pkt_words_q;
            pkt_words_d = '0;
            drop_d      = drop_inc;
            state_d     = bus.s_axis_tlast ? S_IDLE : S_DISCARD;
          end else begin
            do_write    = 1'b1;
            wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(1);
            pkt_words_d = pkt_words_q + OCC_W'(1);
            if (bus.s_axis_tlast) begin
              emit    = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
      S_DISCARD: begin
        if (accept && bus.s_axis_tlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    occ_d = occ_q + OCC_W'(do_write) - OCC_W'(free_ok) - rollback;

    mem_wr_en_d   = do_write;
    mem_wr_addr_d = do_write ? wr_ptr_q : mem_wr_addr_q;
    mem_wr_data_d = do_write ? {bus.s_axis_tlast, bus.s_axis_tdata} : mem_wr_data_q;
    pifo_valid_d  = emit;
    pifo_data_d   = emit ? {1'b1, emit_rank, 12'(emit_sop)} : pifo_data_q;
    // Flag follows the occupancy being loaded this cycle so it lines up with the new count.
    af_d          = (occ_d >= AF_OCC);
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      sop_addr_q    <= '0;
      rank_q        <= '0;
      pkt_words_q   <= '0;
      occ_q         <= '0;
      drop_q        <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
      pifo_valid_q  <= 1'b0;
      pifo_data_q   <= '0;
      af_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      sop_addr_q    <= sop_addr_d;
      rank_q        <= rank_d;
      pkt_words_q   <= pkt_words_d;
      occ_q         <= occ_d;
      drop_q        <= drop_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      pifo_valid_q  <= pifo_valid_d;
      pifo_data_q   <= pifo_data_d;
      af_q          <= af_d;
    end
  end

  assign bus.m_mem_wr_en          = mem_wr_en_q;
  assign bus.m_mem_wr_addr        = mem_wr_addr_q;
  assign bus.m_mem_wr_data        = mem_wr_data_q;
  assign bus.m_pifo_in_valid      = pifo_valid_q;
  assign bus.m_pifo_in_data       = pifo_data_q;
  assign bus.m_buffer_almost_full = af_q;
  assign bus.m_drop_count         = drop_q;

endmodule

// File: tb/tb_pkt_buffer_wr_agent.sv
// Directed bench for pkt_buffer_wr_agent: basic write, orphans, reset mid-packet,
// almost-full threshold, overflow rollback and address wrap.
module tb_pkt_buffer_wr_agent;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  pkt_buffer_wr_agent_if bus ();

  pkt_buffer_wr_agent dut (
    .axis_aclk  (clk),
    .axis_reset (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.s_axis_tdata       = '0;
    bus.s_axis_tuser       = '0;
    bus.s_axis_tvalid      = 1'b0;
    bus.s_axis_tready      = 1'b1;
    bus.s_axis_tlast       = 1'b0;
    bus.s_ctl_pifo_in_en   = 1'b0;
    bus.s_ctl_buffer_wr_en = 1'b1;
    bus.s_free_valid       = 1'b0;
  endtask

  // One beat held for one clock; returns #1 after the edge so registered outputs reflect it.
  task automatic beat(input logic [255:0] d, input logic [18:0] rank, input logic sop,
                      input logic last, input logic free);
    bus.s_axis_tdata             = d;
    bus.s_axis_tuser             = '0;
    bus.s_axis_tuser[48 +: 19]   = rank;
    bus.s_axis_tvalid            = 1'b1;
    bus.s_ctl_pifo_in_en         = sop;
    bus.s_axis_tlast             = last;
    bus.s_free_valid             = free;
    @(posedge clk); #1;
    bus.s_axis_tvalid    = 1'b0;
    bus.s_ctl_pifo_in_en = 1'b0;
    bus.s_axis_tlast     = 1'b0;
    bus.s_free_valid     = 1'b0;
  endtask

  task automatic burst(input int n, input logic [18:0] rank);
    for (int i = 0; i < n; i++) begin
      bus.s_axis_tdata           = 256'(i);
      bus.s_axis_tuser           = '0;
      bus.s_axis_tuser[48 +: 19] = rank;
      bus.s_axis_tvalid          = 1'b1;
      bus.s_ctl_pifo_in_en       = (i == 0);
      bus.s_axis_tlast           = (i == n - 1);
      @(posedge clk); #1;
    end
    bus.s_axis_tvalid    = 1'b0;
    bus.s_ctl_pifo_in_en = 1'b0;
    bus.s_axis_tlast     = 1'b0;
  endtask

  task automatic free_words(input int n);
    bus.s_free_valid = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    bus.s_free_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.s_axis_tvalid    = 1'b1;
    bus.s_ctl_pifo_in_en = 1'b1;
    bus.s_axis_tlast     = 1'b1;
    bus.s_axis_tdata     = '1;
    repeat (3) begin @(posedge clk); #1; end
    if (bus.m_mem_wr_en !== 1'b0) begin $display("FAIL reset_wr_en: got %b required 0", bus.m_mem_wr_en); n_bad++; end
    n_cmp++;
    if (bus.m_mem_wr_addr !== 12'd0) begin $display("FAIL reset_wr_addr: got %0d required 0", bus.m_mem_wr_addr); n_bad++; end
    n_cmp++;
    if (bus.m_mem_wr_data !== 257'd0) begin $display("FAIL reset_wr_data: got %h required 0", bus.m_mem_wr_data); n_bad++; end
    n_cmp++;
    if (bus.m_pifo_in_valid !== 1'b0 || bus.m_pifo_in_data !== 32'd0) begin
      $display("FAIL reset_pifo: got valid=%b data=%h required 0/0", bus.m_pifo_in_valid, bus.m_pifo_in_data); n_bad++;
    end
    n_cmp++;
    if (bus.m_buffer_almost_full !== 1'b0 || bus.m_drop_count !== 32'd0) begin
      $display("FAIL reset_af_drop: got af=%b drop=%0d required 0/0", bus.m_buffer_almost_full, bus.m_drop_count); n_bad++;
    end
    n_cmp++;
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [256:0] exp_d;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      beat(256'hA0 + 256'(i), 19'h00005, (i == 0), (i == 2), 1'b0);
      exp_d = {(i == 2), 256'hA0 + 256'(i)};
      if (bus.m_mem_wr_en !== 1'b1 || bus.m_mem_wr_addr !== 12'(i) || bus.m_mem_wr_data !== exp_d) begin
        $display("FAIL basic_wr[%0d]: got en=%b addr=%0d data=%h required en=1 addr=%0d data=%h",
                 i, bus.m_mem_wr_en, bus.m_mem_wr_addr, bus.m_mem_wr_data, i, exp_d); n_bad++;
      end
      n_cmp++;
      if (bus.m_pifo_in_valid !== (i == 2)) begin
        $display("FAIL basic_push_valid[%0d]: got %b required %b", i, bus.m_pifo_in_valid, (i == 2)); n_bad++;
      end
      n_cmp++;
    end
    if (bus.m_pifo_in_data !== 32'h8000_5000) begin
      $display("FAIL basic_push_data: got %h required 80005000", bus.m_pifo_in_data); n_bad++;
    end
    n_cmp++;
    idle_cycle();
    if (bus.m_pifo_in_valid !== 1'b0 || bus.m_mem_wr_en !== 1'b0) begin
      $display("FAIL basic_after: got push=%b wr_en=%b required 0/0", bus.m_pifo_in_valid, bus.m_mem_wr_en); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_orphan_and_gating();
    // Orphan beat (no PIFO enable) in IDLE
    beat(256'hBAD, 19'h1, 1'b0, 1'b1, 1'b0);
    if (bus.m_mem_wr_en !== 1'b0 || bus.m_pifo_in_valid !== 1'b0) begin
      $display("FAIL orphan: got wr_en=%b push=%b required 0/0", bus.m_mem_wr_en, bus.m_pifo_in_valid); n_bad++;
    end
    n_cmp++;
    bus.s_axis_tready = 1'b0;
    beat(256'hBAD, 19'h1, 1'b1, 1'b1, 1'b0);
    bus.s_axis_tready = 1'b1;
    if (bus.m_mem_wr_en !== 1'b0 || bus.m_pifo_in_valid !== 1'b0) begin
      $display("FAIL tready_low: got wr_en=%b push=%b required 0/0", bus.m_mem_wr_en, bus.m_pifo_in_valid); n_bad++;
    end
    n_cmp++;
    bus.s_ctl_buffer_wr_en = 1'b0;
    beat(256'hBAD, 19'h1, 1'b1, 1'b1, 1'b0);
    bus.s_ctl_buffer_wr_en = 1'b1;
    if (bus.m_mem_wr_en !== 1'b0 || bus.m_pifo_in_valid !== 1'b0) begin
      $display("FAIL wr_en_low: got wr_en=%b push=%b required 0/0", bus.m_mem_wr_en, bus.m_pifo_in_valid); n_bad++;
    end
    n_cmp++;
    beat(256'hC3, 19'h7FFFF, 1'b1, 1'b1, 1'b0);
    if (bus.m_mem_wr_en !== 1'b1 || bus.m_mem_wr_addr !== 12'd3 || bus.m_mem_wr_data !== {1'b1, 256'hC3}) begin
      $display("FAIL single_wr: got en=%b addr=%0d data=%h required 1/3/1_c3", bus.m_mem_wr_en, bus.m_mem_wr_addr, bus.m_mem_wr_data); n_bad++;
    end
    n_cmp++;
    if (bus.m_pifo_in_valid !== 1'b1 || bus.m_pifo_in_data !== 32'hFFFF_F003) begin
      $display("FAIL single_push: got valid=%b data=%h required 1/fffff003", bus.m_pifo_in_valid, bus.m_pifo_in_data); n_bad++;
    end
    n_cmp++;
    idle_cycle();
    if (bus.m_pifo_in_valid !== 1'b0) begin $display("FAIL single_push_pulse: got %b required 0", bus.m_pifo_in_valid); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    beat(256'h10, 19'h2, 1'b1, 1'b0, 1'b0);
    beat(256'h11, 19'h2, 1'b0, 1'b0, 1'b0);
    if (bus.m_mem_wr_en !== 1'b1 || bus.m_mem_wr_addr !== 12'd1) begin
      $display("FAIL midrst_pre: got en=%b addr=%0d required 1/1", bus.m_mem_wr_en, bus.m_mem_wr_addr); n_bad++;
    end
    n_cmp++;
    rst = 1'b1;
    idle_cycle();
    rst = 1'b0;
    if (bus.m_mem_wr_en !== 1'b0) begin $display("FAIL midrst_clear: got wr_en=%b required 0", bus.m_mem_wr_en); n_bad++; end
    n_cmp++;
    for (int i = 0; i < 2; i++) begin
      beat(256'h12 + 256'(i), 19'h2, 1'b0, (i == 1), 1'b0);
      if (bus.m_mem_wr_en !== 1'b0 || bus.m_pifo_in_valid !== 1'b0) begin
        $display("FAIL midrst_tail[%0d]: got wr_en=%b push=%b required 0/0", i, bus.m_mem_wr_en, bus.m_pifo_in_valid); n_bad++;
      end
      n_cmp++;
    end
    beat(256'h20, 19'h9, 1'b1, 1'b0, 1'b0);
    if (bus.m_mem_wr_en !== 1'b1 || bus.m_mem_wr_addr !== 12'd0) begin
      $display("FAIL midrst_next0: got en=%b addr=%0d required 1/0", bus.m_mem_wr_en, bus.m_mem_wr_addr); n_bad++;
    end
    n_cmp++;
    beat(256'h21, 19'h9, 1'b0, 1'b1, 1'b0);
    if (bus.m_mem_wr_addr !== 12'd1 || bus.m_pifo_in_valid !== 1'b1 || bus.m_pifo_in_data !== 32'h8000_9000) begin
      $display("FAIL midrst_next1: got addr=%0d push=%b data=%h required 1/1/80009000",
               bus.m_mem_wr_addr, bus.m_pifo_in_valid, bus.m_pifo_in_data); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_almost_full_overflow();
    do_reset();
    burst(3967, 19'h1);
    if (bus.m_buffer_almost_full !== 1'b0 || bus.m_pifo_in_data !== 32'h8000_1000) begin
      $display("FAIL af_3967: got af=%b push_data=%h required 0/80001000", bus.m_buffer_almost_full, bus.m_pifo_in_data); n_bad++;
    end
    n_cmp++;
    beat(256'h30, 19'h1, 1'b1, 1'b1, 1'b1);
    if (bus.m_mem_wr_addr !== 12'd3967 || bus.m_buffer_almost_full !== 1'b0) begin
      $display("FAIL af_write_free: got addr=%0d af=%b required 3967/0", bus.m_mem_wr_addr, bus.m_buffer_almost_full); n_bad++;
    end
    n_cmp++;
    beat(256'h31, 19'h1, 1'b1, 1'b1, 1'b0);
    if (bus.m_mem_wr_addr !== 12'd3968 || bus.m_buffer_almost_full !== 1'b1) begin
      $display("FAIL af_write: got addr=%0d af=%b required 3968/1", bus.m_mem_wr_addr, bus.m_buffer_almost_full); n_bad++;
    end
    n_cmp++;
    burst(126, 19'h2);
    // Occupancy 4094, wr_ptr 4095: the next packet fills the buffer on its second beat
    beat(256'h40, 19'h3, 1'b1, 1'b0, 1'b0);
    if (bus.m_mem_wr_en !== 1'b1 || bus.m_mem_wr_addr !== 12'd4095) begin
      $display("FAIL ovf_b1: got en=%b addr=%0d required 1/4095", bus.m_mem_wr_en, bus.m_mem_wr_addr); n_bad++;
    end
    n_cmp++;
    beat(256'h41, 19'h3, 1'b0, 1'b0, 1'b0);
    if (bus.m_mem_wr_en !== 1'b1 || bus.m_mem_wr_addr !== 12'd0) begin
      $display("FAIL ovf_b2: got en=%b addr=%0d required 1/0", bus.m_mem_wr_en, bus.m_mem_wr_addr); n_bad++;
    end
    n_cmp++;
    beat(256'h42, 19'h3, 1'b0, 1'b0, 1'b0);
    if (bus.m_mem_wr_en !== 1'b0 || bus.m_drop_count !== 32'd1) begin
      $display("FAIL ovf_b3: got wr_en=%b drop=%0d required 0/1", bus.m_mem_wr_en, bus.m_drop_count); n_bad++;
    end
    n_cmp++;
    for (int i = 0; i < 2; i++) begin
      beat(256'h43 + 256'(i), 19'h3, 1'b0, (i == 1), 1'b0);
      if (bus.m_mem_wr_en !== 1'b0 || bus.m_pifo_in_valid !== 1'b0) begin
        $display("FAIL ovf_discard[%0d]: got wr_en=%b push=%b required 0/0", i, bus.m_mem_wr_en, bus.m_pifo_in_valid); n_bad++;
      end
      n_cmp++;
    end
    idle_cycle();
    if (bus.m_pifo_in_valid !== 1'b0 || bus.m_drop_count !== 32'd1 || bus.m_buffer_almost_full !== 1'b1) begin
      $display("FAIL ovf_after: got push=%b drop=%0d af=%b required 0/1/1",
               bus.m_pifo_in_valid, bus.m_drop_count, bus.m_buffer_almost_full); n_bad++;
    end
    n_cmp++;
    free_words(1);
    beat(256'h50, 19'h4, 1'b1, 1'b1, 1'b0);
    if (bus.m_mem_wr_en !== 1'b1 || bus.m_mem_wr_addr !== 12'd4095 || bus.m_pifo_in_data !== 32'h8000_4FFF) begin
      $display("FAIL ovf_rollback: got en=%b addr=%0d push_data=%h required 1/4095/80004fff",
               bus.m_mem_wr_en, bus.m_mem_wr_addr, bus.m_pifo_in_data); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_wrap();
    logic [11:0] exp_addr [4];
    exp_addr[0] = 12'd4094; exp_addr[1] = 12'd4095; exp_addr[2] = 12'd0; exp_addr[3] = 12'd1;
    do_reset();
    burst(4094, 19'h0);
    free_words(4094);
    for (int i = 0; i < 4; i++) begin
      beat(256'h60 + 256'(i), 19'h12345, (i == 0), (i == 3), 1'b0);
      if (bus.m_mem_wr_en !== 1'b1 || bus.m_mem_wr_addr !== exp_addr[i] || bus.m_mem_wr_data !== {(i == 3), 256'h60 + 256'(i)}) begin
        $display("FAIL wrap_wr[%0d]: got en=%b addr=%0d data=%h required en=1 addr=%0d",
                 i, bus.m_mem_wr_en, bus.m_mem_wr_addr, bus.m_mem_wr_data, exp_addr[i]); n_bad++;
      end
      n_cmp++;
    end
    if (bus.m_pifo_in_valid !== 1'b1 || bus.m_pifo_in_data !== 32'h9234_5FFE || bus.m_buffer_almost_full !== 1'b0) begin
      $display("FAIL wrap_push: got valid=%b data=%h af=%b required 1/92345ffe/0",
               bus.m_pifo_in_valid, bus.m_pifo_in_data, bus.m_buffer_almost_full); n_bad++;
    end
    n_cmp++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_basic();
    test_orphan_and_gating();
    test_reset_mid_packet();
    test_almost_full_overflow();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pkt_buffer_wr_agent.md
PKT_BUFFER_WR_AGENT -- requirements
Module: pkt_buffer_wr_agent

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, meaning packet data beat width.
REQ-002 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, meaning sume metadata width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 12, meaning buffer word address width; DEPTH = 2^ADDR_WIDTH.
REQ-004 SHALL have parameter AF_THRESH, default 3968, meaning occupancy (words) at or above which almost-full asserts.
REQ-005 SHALL have parameter RANK_POS, default 48, meaning LSB of the 19-bit rank in tuser.
REQ-006 Ports, in this order:
- axis_aclk  in  1  sole clock.
- axis_reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  beat data.
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  metadata; valid on SOP beat.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  in  1  enqueue-agent ready, observed only.
- s_axis_tlast  in  1  EOP.
- s_ctl_pifo_in_en  in  1  this queue's pifo enable; high on the SOP beat.
- s_ctl_buffer_wr_en  in  1  this queue's buffer write enable.
- s_free_valid  in  1  read side released one buffer word.
- m_mem_wr_en  out  1  buffer RAM write strobe.
- m_mem_wr_addr  out  ADDR_WIDTH  RAM address.
- m_mem_wr_data  out  C_S_AXIS_DATA_WIDTH+1  {tlast, tdata}.
- m_pifo_in_valid  out  1  one-cycle pifo push.
- m_pifo_in_data  out  32  {valid=1, rank[18:0], sop_addr[11:0]}.
- m_buffer_almost_full  out  1  to the enqueue agent.
- m_drop_count  out  32  packets discarded on overflow.

Function
REQ-007 Beat accepted iff s_axis_tvalid & s_axis_tready & s_ctl_buffer_wr_en.
REQ-008 FSM states IDLE, WRITE, DISCARD; reset state IDLE.
REQ-009 IDLE: accepted beat with s_ctl_pifo_in_en and not full -> write at wr_ptr, latch sop_addr=wr_ptr and rank=tuser[RANK_POS+:19], pkt_words=1; go WRITE, or stay IDLE and emit descriptor if tlast.
REQ-010 IDLE: accepted beat without s_ctl_pifo_in_en (orphan) SHALL be ignored, not written.
REQ-011 WRITE: each accepted beat written at wr_ptr, wr_ptr+1 modulo DEPTH (wraps 4095->0), pkt_words+1; tlast -> emit descriptor, go IDLE.
REQ-012 Full = occupancy == DEPTH; accepted beat while full (any state) SHALL not be written; wr_ptr restored to sop_addr; occupancy reduced by pkt_words; m_drop_count +1 (saturating at 0xFFFFFFFF); go DISCARD, or IDLE if that beat has tlast.
REQ-013 DISCARD: accepted beats not written; tlast -> IDLE; no descriptor.
REQ-014 m_mem_wr_* registered: one cycle after the accepted beat.
REQ-015 m_pifo_in_valid SHALL pulse exactly one cycle, the cycle after the EOP beat is accepted, only for complete packets.
REQ-016 Occupancy (ADDR_WIDTH+1 bits) next = occ + write - s_free_valid - rollback; simultaneous write and free leaves it unchanged; free at occupancy 0 ignored.
REQ-017 m_buffer_almost_full registered: high the cycle after occupancy >= AF_THRESH.

Reset
REQ-018 On axis_reset: FSM IDLE; wr_ptr, occupancy, pkt_words, m_drop_count = 0; all outputs 0.
REQ-019 Reset mid-packet SHALL abandon the packet with no descriptor; its remaining beats are orphans per REQ-010.

Verification
REQ-020 3-beat packet, rank 0x00005, from reset -> RAM writes addr 0,1,2 (bit 256 set on addr 2); one pifo push 0x80005000 the cycle after EOP.
REQ-021 wr_ptr=4094, 4-beat packet -> writes 4094,4095,0,1; sop_addr 4094 in descriptor.
REQ-022 Occupancy 3967, one write plus no free -> almost_full high next cycle; same cycle with s_free_valid -> stays low.
REQ-023 Occupancy 4094, 5-beat packet -> 2 beats written, overflow on beat 3, wr_ptr back to sop, occupancy 4094, drop_count 1, no push, beats 4-5 discarded.
REQ-024 Reset after 2 beats of a 4-beat packet -> beats 3-4 ignored, no push, wr_ptr 0; next packet written at 0.
